// File: rtl/ram_arbiter_ctrl_pkg.sv
// Shared types and constants for the round-robin RAM arbiter controller.
// Optional watchdog is enabled by defining RAM_TIMEOUT_EN.
package ram_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;

    typedef enum logic {
        RAM_OP_READ  = 1'b0,
        RAM_OP_WRITE = 1'b1
    } ram_op_t;

    localparam logic [31:0] RAM_ERR_WORD = 32'hBAD0BAD0;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr,
// scanning upward with wrap; returns one-hot grant, its index and a valid flag.
module rr_arbiter
    import ram_arbiter_ctrl_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    int pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        pos       = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter_ctrl.sv
// Round-robin arbiter of NUM_PORTS requesters onto one RAM port with byte strobes.
// Define RAM_TIMEOUT_EN to add the watchdog and the req_err output.
module ram_arbiter_ctrl
    import ram_arbiter_ctrl_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NUM_PORTS-1:0]          req_ren,
    input  logic [NUM_PORTS-1:0]          req_wen,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_strobe,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic                          ram_ren,
    output logic                          ram_wen,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic [DATA_W/8-1:0]           ram_strobe,
    input  logic [DATA_W-1:0]             ram_rdata,
    input  logic                          ram_ready
`ifdef RAM_TIMEOUT_EN
    ,
    output logic [NUM_PORTS-1:0]          req_err
`endif
);

    localparam int SW = DATA_W / 8;
    localparam int IW = idx_width(NUM_PORTS);

    ram_state_t        state_reg, state_next;
    ram_op_t           op_reg;
    logic [IW-1:0]     grant_reg, ptr_reg, ptr_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg, rdata_reg;
    logic [SW-1:0]     strobe_reg;

    logic [ADDR_W-1:0] addr_arr   [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr  [NUM_PORTS];
    logic [SW-1:0]     strobe_arr [NUM_PORTS];

    logic [NUM_PORTS-1:0] active, arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid, sel_write, in_wait, in_done, timeout_hit;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]  = req_wdata[gi*DATA_W +: DATA_W];
            assign strobe_arr[gi] = req_strobe[gi*SW +: SW];
        end
    endgenerate

    assign active    = req_ren | req_wen;
    assign sel_write = |(req_wen & arb_grant);

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (active),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    assign in_wait  = (state_reg == RAM_WAIT);
    assign in_done  = (state_reg == RAM_DONE);
    assign ptr_next = (grant_reg == IW'(NUM_PORTS - 1)) ? '0 : grant_reg + IW'(1);

`ifdef RAM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]     cnt_reg;
    logic              err_reg;
    logic [DATA_W-1:0] err_data;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_err_word
            assign err_data[gi*8 +: 8] = RAM_ERR_WORD[(gi%4)*8 +: 8];
        end
    endgenerate

    // A ram_ready arriving on the limit cycle wins over the watchdog.
    assign timeout_hit = in_wait && !ram_ready && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (!in_wait) begin
            cnt_reg <= '0;
            if (in_done) begin
                err_reg <= 1'b0;
            end
        end else if (ram_ready) begin
            err_reg <= 1'b0;
        end else if (timeout_hit) begin
            err_reg <= 1'b1;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_err
            assign req_err[gi] = in_done && err_reg && (grant_reg == IW'(gi));
        end
    endgenerate
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RAM_IDLE: if (arb_valid) state_next = RAM_WAIT;
            RAM_WAIT: if (ram_ready || timeout_hit) state_next = RAM_DONE;
            RAM_DONE: state_next = RAM_IDLE;
            default:  state_next = RAM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= RAM_IDLE;
            ptr_reg    <= '0;
            grant_reg  <= '0;
            op_reg     <= RAM_OP_READ;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            strobe_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                RAM_IDLE: begin
                    if (arb_valid) begin
                        grant_reg  <= arb_idx;
                        addr_reg   <= addr_arr[arb_idx];
                        wdata_reg  <= wdata_arr[arb_idx];
                        op_reg     <= sel_write ? RAM_OP_WRITE : RAM_OP_READ;
                        // Reads fetch the whole word; the core extracts sub-words.
                        strobe_reg <= sel_write ? strobe_arr[arb_idx] : '1;
                    end
                end
                RAM_WAIT: begin
                    if (ram_ready) begin
                        rdata_reg <= (op_reg == RAM_OP_READ) ? ram_rdata : '0;
                    end
`ifdef RAM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        rdata_reg <= err_data;
                    end
`endif
                end
                RAM_DONE: begin
                    ptr_reg <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign req_ready[gi] = in_done && (grant_reg == IW'(gi));
        end
    endgenerate

    assign req_rdata  = in_done ? rdata_reg : '0;
    assign ram_ren    = in_wait && (op_reg == RAM_OP_READ);
    assign ram_wen    = in_wait && (op_reg == RAM_OP_WRITE);
    assign ram_addr   = in_wait ? addr_reg   : '0;
    assign ram_wdata  = in_wait ? wdata_reg  : '0;
    assign ram_strobe = in_wait ? strobe_reg : '0;

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Bench for ram_arbiter_ctrl: directed scenarios plus randomized traffic against
// a transaction-level model; honours RAM_TIMEOUT_EN when defined.
module tb_ram_arbiter_ctrl;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              nrst;
    logic [N-1:0]      req_ren, req_wen;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_strobe;
    logic [DW-1:0]     req_rdata;
    logic [N-1:0]      req_ready;
    logic              ram_ren, ram_wen;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [SW-1:0]     ram_strobe;
    logic [DW-1:0]     ram_rdata = '0;
    logic              ram_ready = 1'b0;
`ifdef RAM_TIMEOUT_EN
    logic [N-1:0]      req_err;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter_ctrl #(
        .NUM_PORTS      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_ren    (req_ren),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strobe (req_strobe),
        .req_rdata  (req_rdata),
        .req_ready  (req_ready),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_strobe (ram_strobe),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready)
`ifdef RAM_TIMEOUT_EN
        ,
        .req_err    (req_err)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // RAM responder: ram_ready in WAIT cycle index cur_delay (0 = first WAIT cycle).
    int          delay_cfg = 0;
    bit          rand_delay = 1'b0;
    bit          use_fixed = 1'b1;
    logic [31:0] fixed_rdata = '0;
    int          wc = 0;
    int          cur_delay = 0;
    bit          in_txn = 1'b0;

    always @(posedge clk) begin
        #1;
        if (ram_ren || ram_wen) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                wc     = 0;
`ifdef RAM_TIMEOUT_EN
                cur_delay = rand_delay ? int'($urandom_range(0, 6)) : delay_cfg;
`else
                cur_delay = rand_delay ? int'($urandom_range(0, 3)) : delay_cfg;
`endif
            end else begin
                wc++;
            end
            ram_ready = (wc == cur_delay);
        end else begin
            in_txn    = 1'b0;
            ram_ready = 1'b0;
        end
        ram_rdata = use_fixed ? fixed_rdata : $urandom;
    end

    // Transaction-level model: one request in flight at a time, completion shown
    // for one cycle, pointer moves past the completed port.
    bit          m_inflight = 1'b0;
    bit          m_complete = 1'b0;
    bit          m_write = 1'b0;
    bit          m_err = 1'b0;
    int          m_ptr = 0;
    int          m_port = 0;
    int          m_wc = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_strobe = '0;

    always @(posedge clk) begin : model
        int p;
        bit found;
        if (!nrst) begin
            m_inflight = 1'b0;
            m_complete = 1'b0;
            m_err      = 1'b0;
            m_ptr      = 0;
        end else if (m_complete) begin
            m_complete = 1'b0;
            m_err      = 1'b0;
            m_ptr      = (m_port + 1) % N;
        end else if (m_inflight) begin
            m_wc++;
            if (ram_ready) begin
                m_inflight = 1'b0;
                m_complete = 1'b1;
                m_rdata    = m_write ? 32'h0 : ram_rdata;
                m_err      = 1'b0;
            end
`ifdef RAM_TIMEOUT_EN
            else if (m_wc == TO) begin
                m_inflight = 1'b0;
                m_complete = 1'b1;
                m_rdata    = 32'hBAD0BAD0;
                m_err      = 1'b1;
            end
`endif
        end else begin
            found = 1'b0;
            p     = 0;
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (!found && (req_ren[p] || req_wen[p])) begin
                    found  = 1'b1;
                    m_port = p;
                end
            end
            if (found) begin
                m_inflight = 1'b1;
                m_wc       = 0;
                m_write    = req_wen[m_port];
                m_addr     = req_addr[m_port*AW +: AW];
                m_wdata    = req_wdata[m_port*DW +: DW];
                m_strobe   = m_write ? req_strobe[m_port*SW +: SW] : 4'hF;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin : compare
            logic [N-1:0] e_ready;
            logic [N-1:0] e_err;
            e_ready = '0;
            e_err   = '0;
            if (m_complete) begin
                e_ready[m_port] = 1'b1;
                e_err[m_port]   = m_err;
            end
            chk("req_ready",  req_ready,  e_ready);
            chk("req_rdata",  req_rdata,  m_complete ? m_rdata : 32'h0);
            chk("ram_ren",    ram_ren,    m_inflight && !m_write);
            chk("ram_wen",    ram_wen,    m_inflight && m_write);
            chk("ram_addr",   ram_addr,   m_inflight ? m_addr : 32'h0);
            chk("ram_wdata",  ram_wdata,  m_inflight ? m_wdata : 32'h0);
            chk("ram_strobe", ram_strobe, m_inflight ? m_strobe : 4'h0);
`ifdef RAM_TIMEOUT_EN
            chk("req_err",    req_err,    e_err);
`endif
            if (req_ready != '0)
                $display("txn t=%0t ready=%b rdata=%h", $time, req_ready, req_rdata);
        end
    end

    task automatic set_req(input int p, input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_ren[p]               = r;
        req_wen[p]               = w;
        req_addr[p*AW +: AW]     = a;
        req_wdata[p*DW +: DW]    = d;
        req_strobe[p*SW +: SW]   = s;
    endtask

    task automatic clr_all();
        req_ren = '0;
        req_wen = '0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of clock edges until req_ready is seen, or -1.
    task automatic wait_ready(input int limit, output int edges);
        edges = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (req_ready != '0) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: no req_ready within %0d cycles", limit);
        end
    endtask

    task automatic count_quiet(input string nm, input int n);
        int pulses;
        int busy;
        pulses = 0;
        busy   = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (req_ready != '0) pulses++;
            if (ram_ren || ram_wen) busy++;
        end
        chk({nm, "_extra_ready"}, pulses, 0);
        chk({nm, "_extra_ram_op"}, busy, 0);
    endtask

    initial begin
        int           e;
        logic [N-1:0] seq [4];
        int           gap [4];

        nrst       = 1'b0;
        req_ren    = '0;
        req_wen    = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_strobe = '0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        step(1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ram_ren", ram_ren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        nrst = 1'b1;
        step(1);

        // Port 0 read, ready in the second WAIT cycle.
        use_fixed = 1'b1; fixed_rdata = 32'hDEADBEEF; delay_cfg = 1;
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        wait_ready(10, e);
        chk("t1_latency", e, 3);
        chk("t1_ready", req_ready, 3'b001);
        chk("t1_rdata", req_rdata, 32'hDEADBEEF);
        clr_all();
        step(1);
        chk("t1_model_ptr", m_ptr, 1);
        chk("t1_idle_ready", req_ready, 0);

        // Port 1 half-word write held stable for three WAIT cycles.
        delay_cfg = 2;
        set_req(1, 1'b0, 1'b1, 32'h204, 32'h11223344, 4'b0011);
        step(1);
        chk("t2_ram_wen", ram_wen, 1);
        chk("t2_ram_strobe", ram_strobe, 4'b0011);
        chk("t2_ram_wdata", ram_wdata, 32'h11223344);
        chk("t2_ram_addr", ram_addr, 32'h204);
        wait_ready(10, e);
        chk("t2_latency", e, 3);
        chk("t2_ready", req_ready, 3'b010);
        chk("t2_rdata", req_rdata, 0);
        clr_all();
        count_quiet("t2", 5);

        // Ports 0 and 1 requesting continuously with immediate ram_ready.
        delay_cfg = 0;
        set_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h304, 32'h0, 4'h0);
        for (int t = 0; t < 4; t++) begin
            wait_ready(10, e);
            seq[t] = req_ready;
            gap[t] = e;
        end
        clr_all();
        chk("t3_grant0", seq[0], 3'b001);
        chk("t3_grant1", seq[1], 3'b010);
        chk("t3_grant2", seq[2], 3'b001);
        chk("t3_grant3", seq[3], 3'b010);
        chk("t3_first_latency", gap[0], 2);
        chk("t3_spacing1", gap[1], 3);
        chk("t3_spacing3", gap[3], 3);
        count_quiet("t3", 4);

        // Port 0 drops its read mid-WAIT; the transaction still completes.
        delay_cfg = 2;
        set_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        step(2);
        clr_all();
        wait_ready(10, e);
        chk("t4_latency", e, 2);
        chk("t4_ready", req_ready, 3'b001);
        count_quiet("t4", 6);

        // Reset in the middle of WAIT abandons the transaction.
        delay_cfg = 1000;
        set_req(2, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        step(3);
        chk("t5_in_wait", ram_ren, 1);
        nrst = 1'b0;
        clr_all();
        step(1);
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_ren", ram_ren, 0);
        chk("t5_rst_addr", ram_addr, 0);
        chk("t5_rst_strobe", ram_strobe, 0);
        chk("t5_rst_rdata", req_rdata, 0);
        nrst = 1'b1;
        count_quiet("t5", 6);

`ifdef RAM_TIMEOUT_EN
        // Watchdog expiry after TO WAIT cycles, then ram_ready on the limit cycle.
        delay_cfg = 1000;
        set_req(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        wait_ready(12, e);
        chk("t6_to_latency", e, TO + 1);
        chk("t6_to_ready", req_ready, 3'b001);
        chk("t6_to_err", req_err, 3'b001);
        chk("t6_to_rdata", req_rdata, 32'hBAD0BAD0);
        clr_all();
        step(3);
        delay_cfg = TO - 1; fixed_rdata = 32'h600DF00D;
        set_req(0, 1'b1, 1'b0, 32'h604, 32'h0, 4'h0);
        wait_ready(12, e);
        chk("t6_ok_latency", e, TO + 1);
        chk("t6_ok_err", req_err, 0);
        chk("t6_ok_rdata", req_rdata, 32'h600DF00D);
        clr_all();
        step(3);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        rand_delay = 1'b1;
        use_fixed  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                int r;
                r = int'($urandom_range(0, 3));
                set_req(p, (r == 1) || (r == 3), (r >= 2), $urandom, $urandom,
                        4'($urandom_range(0, 15)));
            end
            step(1);
        end
        clr_all();
        step(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
